fifo_ctrl8: RTL and testbench

FIFO_CTRL8 -- requirements
Module: fifo_ctrl8

---
 rtl/fifo_ctrl8_if.sv | 24 ++
 rtl/fifo_ctrl8.sv | 121 ++++++++++++
 tb/tb_fifo_ctrl8.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/fifo_ctrl8_if.sv
// Handshake/status bundle between a FIFO requester and the fifo_ctrl8 controller.
interface fifo_ctrl8_if;
  logic       wr_req;
  logic       rd_req;
  logic [7:0] wr_load;
  logic [2:0] rd_sel;
  logic       wr_ack;
  logic       rd_ack;
  logic       wr_err;
  logic       rd_err;
  logic       full;
  logic       empty;
  logic [3:0] count;

  modport master (
    output wr_req, rd_req,
    input  wr_load, rd_sel, wr_ack, rd_ack, wr_err, rd_err, full, empty, count
  );

  modport slave (
    input  wr_req, rd_req,
    output wr_load, rd_sel, wr_ack, rd_ack, wr_err, rd_err, full, empty, count
  );
endinterface

// File: rtl/fifo_ctrl8.sv
// 8-entry FIFO controller driving an external 8 x 4-bit register datapath.
// Optional macro FIFO_CTRL8_SIMUL_RW_EN: accept a write and a read in the same cycle.
module fifo_ctrl8 (
  input  logic         clk,
  input  logic         reset,
  fifo_ctrl8_if.slave  bus
);

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_WRITE,
    ST_WR_ERR,
    ST_READ,
    ST_RD_ERR
`ifdef FIFO_CTRL8_SIMUL_RW_EN
    , ST_WR_RD
`endif
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] head_q, head_d;
  logic [2:0] tail_q, tail_d;
  logic [3:0] count_q, count_d;
  logic [2:0] rd_sel_q, rd_sel_d;
  logic       wr_acc, rd_acc;
  logic       full_c, empty_c;

  assign full_c  = (count_q == 4'd8);
  assign empty_c = (count_q == 4'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_INIT;
      head_q   <= 3'd0;
      tail_q   <= 3'd0;
      count_q  <= 4'd0;
      rd_sel_q <= 3'd0;
    end else begin
      state_q  <= state_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      rd_sel_q <= rd_sel_d;
    end
  end

  always_comb begin
    state_d  = ST_IDLE;
    head_d   = head_q;
    tail_d   = tail_q;
    rd_sel_d = rd_sel_q;
    wr_acc   = 1'b0;
    rd_acc   = 1'b0;
`ifdef FIFO_CTRL8_SIMUL_RW_EN
    if (bus.wr_req && bus.rd_req) begin
      if (empty_c) begin
        wr_acc  = 1'b1;
        state_d = ST_WRITE;
      end else if (full_c) begin
        rd_acc  = 1'b1;
        state_d = ST_READ;
      end else begin
        wr_acc  = 1'b1;
        rd_acc  = 1'b1;
        state_d = ST_WR_RD;
      end
    end else
`endif
    // Without simultaneous support a pending read wins and the write is simply dropped.
    if (bus.rd_req) begin
      if (!empty_c) begin
        rd_acc  = 1'b1;
        state_d = ST_READ;
      end else begin
        state_d = ST_RD_ERR;
      end
    end else if (bus.wr_req) begin
      if (!full_c) begin
        wr_acc  = 1'b1;
        state_d = ST_WRITE;
      end else begin
        state_d = ST_WR_ERR;
      end
    end
    if (wr_acc) tail_d = tail_q + 3'd1;
    if (rd_acc) begin
      head_d   = head_q + 3'd1;
      rd_sel_d = head_q;
    end
    count_d = count_q + {3'b000, wr_acc} - {3'b000, rd_acc};
  end

  always_comb begin
    bus.wr_ack = 1'b0;
    bus.rd_ack = 1'b0;
    bus.wr_err = 1'b0;
    bus.rd_err = 1'b0;
    case (state_q)
      ST_WRITE:  bus.wr_ack = 1'b1;
      ST_WR_ERR: bus.wr_err = 1'b1;
      ST_READ:   bus.rd_ack = 1'b1;
      ST_RD_ERR: bus.rd_err = 1'b1;
`ifdef FIFO_CTRL8_SIMUL_RW_EN
      ST_WR_RD: begin
        bus.wr_ack = 1'b1;
        bus.rd_ack = 1'b1;
      end
`endif
      default: ;
    endcase
    // Requests are ignored while reset is held, so no load strobe may escape.
    bus.wr_load = (wr_acc && !reset) ? (8'b0000_0001 << tail_q) : 8'b0000_0000;
  end

  assign bus.rd_sel = rd_sel_q;
  assign bus.count  = count_q;
  assign bus.full   = full_c;
  assign bus.empty  = empty_c;

endmodule

// File: tb/tb_fifo_ctrl8.sv
// Directed table-driven bench for fifo_ctrl8, plus reset corner sequences.
module tb_fifo_ctrl8;

  logic clk;
  logic reset;
  fifo_ctrl8_if bus_if ();

  fifo_ctrl8 dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       wr;
    logic       rd;
    logic [7:0] load;
    logic       wack;
    logic       werr;
    logic       rack;
    logic       rerr;
    int         cnt;
    int         sel;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp;
  int   n_fail;

  function automatic void push(logic w, logic r, logic [7:0] ld, logic wa, logic we,
                               logic ra, logic re, int c, int s);
    vec_t v;
    v.wr = w; v.rd = r; v.load = ld; v.wack = wa; v.werr = we;
    v.rack = ra; v.rerr = re; v.cnt = c; v.sel = s;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_idle_flags(input string tag);
    chk({tag, ".wr_ack"}, int'(bus_if.wr_ack), 0);
    chk({tag, ".rd_ack"}, int'(bus_if.rd_ack), 0);
    chk({tag, ".wr_err"}, int'(bus_if.wr_err), 0);
    chk({tag, ".rd_err"}, int'(bus_if.rd_err), 0);
  endtask

  task automatic step(input int idx, input vec_t v);
    string tag;
    tag = $sformatf("v%0d", idx);
    @(negedge clk);
    bus_if.wr_req = v.wr;
    bus_if.rd_req = v.rd;
    #1;
    chk({tag, ".wr_load"}, int'(bus_if.wr_load), int'(v.load));
    @(posedge clk);
    #1;
    chk({tag, ".wr_ack"}, int'(bus_if.wr_ack), int'(v.wack));
    chk({tag, ".wr_err"}, int'(bus_if.wr_err), int'(v.werr));
    chk({tag, ".rd_ack"}, int'(bus_if.rd_ack), int'(v.rack));
    chk({tag, ".rd_err"}, int'(bus_if.rd_err), int'(v.rerr));
    chk({tag, ".count"},  int'(bus_if.count),  v.cnt);
    chk({tag, ".rd_sel"}, int'(bus_if.rd_sel), v.sel);
    chk({tag, ".full"},   int'(bus_if.full),   (v.cnt == 8) ? 1 : 0);
    chk({tag, ".empty"},  int'(bus_if.empty),  (v.cnt == 0) ? 1 : 0);
  endtask

  logic [7:0] wrap_loads [6];

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    wrap_loads = '{8'h20, 8'h40, 8'h80, 8'h01, 8'h02, 8'h04};

    // Fill: 8 writes, then one rejected write while full.
    for (int i = 0; i < 8; i++) push(1, 0, 8'(1 << i), 1, 0, 0, 0, i + 1, 0);
    push(1, 0, 8'h00, 0, 1, 0, 0, 8, 0);
    // Drain: 8 reads, a rejected read, then an idle cycle.
    for (int i = 0; i < 8; i++) push(0, 1, 8'h00, 0, 0, 1, 0, 7 - i, i);
    push(0, 1, 8'h00, 0, 0, 0, 1, 0, 7);
    push(0, 0, 8'h00, 0, 0, 0, 0, 0, 7);
    // Wrap-around: 5 writes, 5 reads, 6 writes.
    for (int i = 0; i < 5; i++) push(1, 0, 8'(1 << i), 1, 0, 0, 0, i + 1, 7);
    for (int i = 0; i < 5; i++) push(0, 1, 8'h00, 0, 0, 1, 0, 4 - i, i);
    for (int i = 0; i < 6; i++) push(1, 0, wrap_loads[i], 1, 0, 0, 0, i + 1, 4);
    // Bring count to 3 (head 5 -> 0, tail stays 3), then both requests together.
    for (int i = 0; i < 3; i++) push(0, 1, 8'h00, 0, 0, 1, 0, 5 - i, 5 + i);
`ifdef FIFO_CTRL8_SIMUL_RW_EN
    push(1, 1, 8'h08, 1, 0, 1, 0, 3, 0);
`else
    push(1, 1, 8'h00, 0, 0, 1, 0, 2, 0);
`endif

    // Reset held with a write request pending: nothing may be loaded.
    reset = 1'b1;
    bus_if.wr_req = 1'b1;
    bus_if.rd_req = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.wr_load", int'(bus_if.wr_load), 0);
    chk("rst.count",   int'(bus_if.count),   0);
    chk("rst.empty",   int'(bus_if.empty),   1);
    chk("rst.full",    int'(bus_if.full),    0);
    chk("rst.rd_sel",  int'(bus_if.rd_sel),  0);
    chk_idle_flags("rst");

    bus_if.wr_req = 1'b0;
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("init2idle.count", int'(bus_if.count), 0);
    chk_idle_flags("init2idle");

    for (int i = 0; i < vecs.size(); i++) step(i, vecs[i]);

    // Mid-burst asynchronous reset at count 5.
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      vec_t v;
      v.wr = 1; v.rd = 0; v.load = 8'(1 << i); v.wack = 1; v.werr = 0;
      v.rack = 0; v.rerr = 0; v.cnt = i + 1; v.sel = 0;
      step(100 + i, v);
    end
    @(negedge clk);
    bus_if.wr_req = 1'b1;
    #1;
    chk("burst.wack_before", int'(bus_if.wr_ack), 1);
    chk("burst.load_before", int'(bus_if.wr_load), 8'h20);
    #1;
    reset = 1'b1;
    #1;
    chk("async.count",   int'(bus_if.count),   0);
    chk("async.empty",   int'(bus_if.empty),   1);
    chk("async.full",    int'(bus_if.full),    0);
    chk("async.wr_load", int'(bus_if.wr_load), 0);
    chk("async.rd_sel",  int'(bus_if.rd_sel),  0);
    chk_idle_flags("async");
    @(negedge clk);
    bus_if.wr_req = 1'b0;
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst.count", int'(bus_if.count), 0);
    begin
      vec_t v;
      v.wr = 1; v.rd = 0; v.load = 8'h01; v.wack = 1; v.werr = 0;
      v.rack = 0; v.rerr = 0; v.cnt = 1; v.sel = 0;
      step(200, v);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
